// File: rtl/toggle_activity_monitor.sv
// Toggle activity monitor: counts transitions on four sub-circuit inputs and one output
// over a programmable window, then holds the per-net counts until the report is accepted.
module toggle_activity_monitor #(
    parameter int CNT_W = 16,
    parameter int NNET  = 5,
    // A window may be made wider than a counter so that saturation is actually reachable.
    parameter int WIN_W = CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIN_W-1:0]       win_len,
    input  logic                   n_1,
    input  logic                   n_2,
    input  logic                   n_3,
    input  logic                   n_4,
    input  logic                   n_8,
    output logic                   busy,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [NNET*CNT_W-1:0]  tgl_cnt,
    output logic [NNET-1:0]        ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        COUNT  = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   cyc_q;
    logic [WIN_W-1:0]   cyc_nxt;
    logic [NNET-1:0]    prev_q;
    logic [NNET-1:0]    cur;
    logic [CNT_W-1:0]   cnt_q [NNET];
    logic [CNT_W-1:0]   cnt_d [NNET];
    logic [NNET-1:0]    ovf_q;
    logic [NNET-1:0]    ovf_d;
    logic               busy_q;
    logic               valid_q;

    // Slice k of every per-net vector: k=0..3 are n_1..n_4, k=4 is n_8.
    assign cur     = NNET'({n_8, n_4, n_3, n_2, n_1});
    assign cyc_nxt = cyc_q + WIN_W'(1);

    // Next counter values for one COUNT cycle: saturate and flag instead of wrapping.
    always_comb begin
        for (int k = 0; k < NNET; k++) begin
            // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (cur[k] != prev_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and keeps the report clean.
            state_q <= IDLE;
            win_q   <= '0;
            cyc_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
            ovf_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees the pre-edge values of the others.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q  <= '{default: '0};
                        ovf_q  <= '0;
                        cyc_q  <= '0;
                        busy_q <= 1'b1;
                        if (win_len != '0) begin
                            win_q   <= win_len;
                            state_q <= PRIME;
                        end else begin
                            state_q <= REPORT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                PRIME: begin
                    prev_q  <= cur;
                    state_q <= COUNT;
                end
                COUNT: begin
                    prev_q <= cur;
                    cnt_q  <= cnt_d;
                    ovf_q  <= ovf_d;
                    cyc_q  <= cyc_nxt;
                    if (cyc_nxt == win_q) begin
                        state_q <= REPORT;
                        valid_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign rpt_valid = valid_q;
    assign ovf       = ovf_q;

    for (genvar k = 0; k < NNET; k++) begin : g_pack
        assign tgl_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: a 16-bit and a 4-bit-counter instance run in lockstep
// against a transition-counting model built from the recorded input history.
module tb_toggle_activity_monitor;

    localparam int CW  = 16;
    localparam int CW4 = 4;
    localparam int WW4 = 8;
    localparam int NN  = 5;
    localparam int HN  = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rpt_ready;
    logic [CW-1:0]     win_len;
    logic [4:0]        nets;          // {n_8, n_4, n_3, n_2, n_1}
    logic              busy, rpt_valid, busy4, rpt_valid4;
    logic [NN*CW-1:0]  tgl_cnt;
    logic [NN*CW4-1:0] tgl_cnt4;
    logic [NN-1:0]     ovf, ovf4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_activity_monitor #(.CNT_W(CW), .NNET(NN)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .n_1(nets[0]), .n_2(nets[1]), .n_3(nets[2]), .n_4(nets[3]), .n_8(nets[4]),
        .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .tgl_cnt(tgl_cnt), .ovf(ovf)
    );

    toggle_activity_monitor #(.CNT_W(CW4), .NNET(NN), .WIN_W(WW4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len[WW4-1:0]),
        .n_1(nets[0]), .n_2(nets[1]), .n_3(nets[2]), .n_4(nets[3]), .n_8(nets[4]),
        .busy(busy4), .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready),
        .tgl_cnt(tgl_cnt4), .ovf(ovf4)
    );

    task automatic check(input string name, input logic [NN*CW-1:0] act, input logic [NN*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Window result = number of differing consecutive samples, taken over the samples seen at
    // the win_len+1 edges following the accepted start edge, then clipped to the counter range.
    logic [4:0]  hist [HN];
    int unsigned raw [NN];
    logic        m_busy   = 1'b0;
    logic        m_valid  = 1'b0;
    int          edge_idx = 0;
    int          rep_edge = 0;
    int          m_win    = 0;

    initial begin
        logic [4:0] d;
        foreach (raw[k]) raw[k] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
                foreach (raw[k]) raw[k] = 0;
            end else begin
                edge_idx++;
                hist[edge_idx % HN] = nets;
                if (m_valid && rpt_ready) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b0;
                end else if (!m_busy && start) begin
                    m_busy = 1'b1;
                    m_win  = int'(win_len);
                    foreach (raw[k]) raw[k] = 0;
                    rep_edge = edge_idx + ((m_win == 0) ? 0 : m_win + 1);
                    if (m_win == 0) m_valid = 1'b1;
                end else if (m_busy && !m_valid && edge_idx == rep_edge) begin
                    for (int j = rep_edge - m_win + 1; j <= rep_edge; j++) begin
                        d = hist[j % HN] ^ hist[(j - 1) % HN];
                        for (int k = 0; k < NN; k++) raw[k] += d[k];
                    end
                    m_valid = 1'b1;
                end
            end
        end
    end

    function automatic logic [NN*CW-1:0] exp_cnt(input int unsigned maxv, input int w);
        logic [NN*CW-1:0] r;
        int unsigned v;
        r = '0;
        for (int k = 0; k < NN; k++) begin
            v = (raw[k] > maxv) ? maxv : raw[k];
            r[k*w +: CW] = CW'(v);
        end
        return r;
    endfunction

    function automatic logic [NN-1:0] exp_ovf(input int unsigned maxv);
        logic [NN-1:0] r;
        for (int k = 0; k < NN; k++) r[k] = (raw[k] > maxv);
        return r;
    endfunction

    // One compare process: handshake every cycle, counts whenever they are meant to be visible.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, m_busy);
            check("rpt_valid", rpt_valid, m_valid);
            check("busy4", busy4, m_busy);
            check("rpt_valid4", rpt_valid4, m_valid);
            if (m_valid || !m_busy) begin
                check("tgl_cnt", tgl_cnt, exp_cnt(65535, CW));
                check("ovf", ovf, exp_ovf(65535));
                check("tgl_cnt4", tgl_cnt4, exp_cnt(15, CW4));
                check("ovf4", ovf4, exp_ovf(15));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic s, input logic [4:0] v, input logic rdy);
        start     = s;
        nets      = v;
        rpt_ready = rdy;
        @(negedge clk);
    endtask

    function automatic logic [4:0] sweep(input int i);
        logic [3:0] b;
        logic n1, n2, n3, n4, n8;
        b  = 4'(i);
        n1 = b[3]; n2 = b[2]; n3 = b[1]; n4 = b[0];
        n8 = (n1 ^ n2) & (n3 | (n1 ^ n4));
        return {n8, n4, n3, n2, n1};
    endfunction

    initial begin
        logic [4:0]       v;
        logic [NN*CW-1:0] snap;
        int               lat;

        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]       v;
        logic [NN*CW-1:0] snap;
        int               lat;

        rst = 1'b1; start = 1'b1; win_len = 16'd4; nets = '0; rpt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cnt", tgl_cnt, '0);
        check("rst_busy", busy, 1'b0);

        // Window of 4 with n_1 toggling; start coincides with reset release.
        rst = 1'b0;
        drive(1'b1, 5'b0, 1'b0);
        check("t1_busy", busy, 1'b1);
        v = '0; lat = 1;
        while (!rpt_valid && lat < 50) begin
            v[0] = ~v[0];
            drive(1'b0, v, 1'b0);
            lat++;
        end
        check("t1_latency", lat, 6);
        check("t1_net0", tgl_cnt[CW-1:0], 4);
        check("t1_others", tgl_cnt[NN*CW-1:CW], '0);
        check("t1_ovf", ovf, '0);
        drive(1'b0, v, 1'b1);
        check("t1_accept_valid", rpt_valid, 1'b0);
        check("t1_idle_net0", tgl_cnt[CW-1:0], 4);
        repeat (2) drive(1'b0, '0, 1'b0);

        // Full input sweep with the golden output function.
        win_len = 16'd8;
        drive(1'b1, sweep(0), 1'b0);
        drive(1'b0, sweep(0), 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, sweep(i), 1'b0);
        check("t2_valid", rpt_valid, 1'b1);
        check("t2_counts", tgl_cnt, {16'd1, 16'd7, 16'd3, 16'd1, 16'd0});

        // Back-pressure: report must hold for 10 cycles while inputs keep moving.
        snap = tgl_cnt;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'($urandom), 1'b0);
            check("t3_hold_cnt", tgl_cnt, snap);
            check("t3_hold_valid", rpt_valid, 1'b1);
        end
        drive(1'b0, '0, 1'b1);
        check("t3_after_valid", rpt_valid, 1'b0);
        check("t3_after_busy", busy, 1'b0);
        drive(1'b0, '0, 1'b0);

        // Saturation on the 4-bit instance: 20 toggles of n_2.
        win_len = 16'd20;
        drive(1'b1, '0, 1'b0);
        v = '0;
        for (int i = 0; i < 21; i++) begin
            v[1] = ~v[1];
            drive(1'b0, v, 1'b0);
        end
        check("t4_valid", rpt_valid4, 1'b1);
        check("t4_net1_sat", tgl_cnt4[2*CW4-1:CW4], 4'd15);
        check("t4_ovf4", ovf4, 5'b00010);
        check("t4_net1_wide", tgl_cnt[2*CW-1:CW], 20);
        check("t4_ovf_wide", ovf, '0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Asynchronous reset in the middle of a window.
        win_len = 16'd10;
        drive(1'b1, '0, 1'b0);
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[2] = ~v[2];
            drive(1'b0, v, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_valid", rpt_valid, 1'b0);
        check("t5_cnt", tgl_cnt, '0);
        check("t5_ovf", ovf, '0);
        check("t5_cnt4", tgl_cnt4, '0);
        @(negedge clk);
        rst = 1'b0;
        win_len = 16'd2;
        drive(1'b1, 5'b0, 1'b0);
        drive(1'b0, 5'b1, 1'b0);
        drive(1'b0, 5'b0, 1'b0);
        drive(1'b0, 5'b1, 1'b0);
        check("t5_new_valid", rpt_valid, 1'b1);
        check("t5_new_net0", tgl_cnt[CW-1:0], 2);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Zero-length window, plus a start pulse during REPORT that must be ignored.
        win_len = 16'd0;
        drive(1'b1, 5'h1F, 1'b0);
        check("t6_valid", rpt_valid, 1'b1);
        check("t6_cnt", tgl_cnt, '0);
        win_len = 16'd5;
        drive(1'b1, 5'h0A, 1'b0);
        check("t6_still_valid", rpt_valid, 1'b1);
        check("t6_still_cnt", tgl_cnt, '0);
        drive(1'b0, '0, 1'b1);
        check("t6_accept_valid", rpt_valid, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("t6_idle_busy", busy, 1'b0);
        repeat (2) drive(1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of each toggle counter and of win_len.
REQ-002 Parameter NNET, default 5, number of monitored nets (4 sub-circuit inputs plus 1 output).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a measurement window; honoured only in IDLE.
REQ-006 win_len  input  CNT_W  window length in sample cycles; sampled at accepted start.
REQ-007 n_1, n_2, n_3, n_4  input  1 each  sub-circuit primary inputs being monitored.
REQ-008 n_8  input  1  sub-circuit output being monitored.
REQ-009 busy  output  1  high from accepted start until the report is accepted.
REQ-010 rpt_valid  output  1  report available.
REQ-011 rpt_ready  input  1  consumer accepts the report when rpt_valid and rpt_ready are both high at a rising edge.
REQ-012 tgl_cnt  output  NNET*CNT_W  packed toggle counts; slice k*CNT_W holds net k (k=0..3: n_1..n_4; k=4: n_8).
REQ-013 ovf  output  NNET  per-net saturation flag.

Function
REQ-014 FSM states: IDLE, PRIME, COUNT, REPORT; encoding is free.
REQ-015 IDLE: start=1 and win_len!=0 -> PRIME; win_len latched, counters and ovf cleared on the same edge.
REQ-016 IDLE: start=1 and win_len=0 -> REPORT directly with all counts 0 and ovf 0.
REQ-017 PRIME: capture {n_8,n_4,n_3,n_2,n_1} into the previous-sample register; no counting; -> COUNT on the next edge.
REQ-018 COUNT: each cycle, for every net where current != previous sample, increment that net's counter; previous-sample register updated every cycle.
REQ-019 COUNT: a cycle counter increments once per COUNT cycle; after exactly win_len COUNT cycles -> REPORT.
REQ-020 Toggle counters saturate at 2^CNT_W-1; an increment attempted at saturation sets the matching ovf bit, which stays set until the next accepted start.
REQ-021 REPORT: rpt_valid=1; tgl_cnt and ovf held stable while rpt_valid=1 and rpt_ready=0.
REQ-022 REPORT with rpt_ready=1 -> IDLE on that edge; rpt_valid low the following cycle.
REQ-023 busy=1 in PRIME, COUNT and REPORT; busy=0 in IDLE.
REQ-024 start outside IDLE is ignored and has no effect on the window in progress.
REQ-025 Counts are total transitions (rise plus fall); the value seen at PRIME is never counted.
REQ-026 Latency: the first countable transition is between the PRIME sample and the first COUNT sample; rpt_valid rises win_len+2 cycles after the accepted start edge.
REQ-027 tgl_cnt and ovf remain readable in IDLE after a report until the next accepted start.

Reset
REQ-028 rst high forces IDLE asynchronously, in any state including mid-window.
REQ-029 Reset values: busy=0, rpt_valid=0, tgl_cnt=0, ovf=0, cycle counter=0, previous-sample register=0.
REQ-030 A start pulse coincident with rst is ignored; the first start is honoured on the first edge after rst deasserts.

Verification
REQ-031 start, win_len=4, n_1 toggles every cycle, other nets constant -> rpt_valid 6 cycles after start, net0 count=4, all other counts 0, ovf=0.
REQ-032 start, win_len=8, drive the full sweep n_1..n_4 = 0000..0111 with n_8 from the golden function n_8=(n_1^n_2)&(n_3|(n_1^n_4)) -> each count equals the transitions computed from that sequence by the bench model.
REQ-033 CNT_W=4, win_len=15+, n_2 toggling every cycle -> net1 count=15 (saturated), ovf[1]=1, all other ovf bits 0.
REQ-034 REPORT with rpt_ready held low for 10 cycles, then high -> tgl_cnt stable for all 10 cycles; IDLE and rpt_valid=0 on the cycle after acceptance.
REQ-035 rst asserted for one cycle mid-COUNT -> busy, rpt_valid, tgl_cnt and ovf all 0 immediately; a new start with win_len=2 then completes normally.
REQ-036 start with win_len=0 -> rpt_valid on the next cycle with all counts 0; a second start pulsed during REPORT is ignored.
